imem_loadable: RTL and testbench

//  Parametrised, run-time-loadable instruction memory for the single-cycle MIPS core.

---
 rtl/imem_loadable.sv | 123 ++++++++++++
 tb/tb_imem_loadable.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory for the single-cycle MIPS core.
// A program is streamed in over a valid/ready port; fetch is a combinational read.
module imem_loadable #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 6,
    parameter int unsigned       DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W+1:0] addr,
    output logic [DATA_W-1:0] instr,
    output logic              fetch_fault,
    output logic              stall,
    input  logic              load_mode,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_LOAD
    } state_t;

    localparam int unsigned    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    state_t              state;
    logic [ADDR_W:0]     ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    logic [ADDR_W-1:0]   widx;
    logic                aligned;
    logic                in_range;

    // ptr is one bit wider than a word index so it can reach DEPTH and close the port.
    assign wr_ready = (state == ST_LOAD) && (ptr < DEPTH_C);
    assign stall    = (state != ST_RUN);

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = NOP_WORD;
        if (reset) begin
            if (state == ST_CLEAR) begin
                mem_we = 1'b1;
            end else if (state == ST_LOAD && wr_valid && wr_ready) begin
                mem_we    = 1'b1;
                mem_wdata = wr_data;
            end
        end
    end

    // NOTE: the array has no reset branch; the CLEAR sweep initialises it one word per
    // cycle, which keeps it mappable onto plain RAM instead of a wall of flops.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr[IDX_W-1:0]] <= mem_wdata;
        end
    end

    // NOTE: all state below updates with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            load_done  <= 1'b0;
            load_count <= '0;
            overflow   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (ptr == LAST_C) begin
                        state <= ST_RUN;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + ONE_C;
                    end
                end
                ST_RUN: begin
                    if (load_mode) begin
                        state      <= ST_LOAD;
                        ptr        <= '0;
                        load_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (wr_valid && wr_ready) begin
                        ptr        <= ptr + ONE_C;
                        load_count <= load_count + ONE_C;
                    end else if (wr_valid) begin
                        overflow <= 1'b1;
                    end
                    // A beat offered in the exit cycle is still taken above.
                    if (!load_mode) begin
                        state     <= ST_RUN;
                        load_done <= 1'b1;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    assign widx        = addr[ADDR_W+1:2];
    assign aligned     = (addr[1:0] == 2'b00);
    assign in_range    = ({1'b0, widx} < DEPTH_C);
    assign fetch_fault = !aligned || !in_range;

    // Out-of-range reads are gated before the array is indexed, so instr is never X.
    assign instr = (state == ST_RUN && aligned && in_range) ? mem[widx[IDX_W-1:0]] : NOP_WORD;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: clear sweep, loads, overflow, faults, reset abort.
// Expected fetch data is queued when words are streamed and popped on readback.
module tb_imem_loadable;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  addr;
    logic        load_mode, wr_valid;
    logic [31:0] wr_data;
    logic        ld16, wv16;
    logic [31:0] wd16;

    logic [31:0] instr, instr16, instr48;
    logic        fetch_fault, fault16, fault48;
    logic        stall, stall16, stall48;
    logic        wr_ready, ready16, ready48;
    logic        load_done, done16, done48;
    logic [6:0]  load_count, count16, count48;
    logic        overflow, ovf16, ovf48;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } sb_t;

    sb_t         sb64[$];
    sb_t         sb16[$];
    logic [31:0] stream_q[$];

    logic [31:0] prog [22] = '{
        32'h20020005, 32'h2003000c, 32'h04000000, 32'h00e22025, 32'h00642824,
        32'h00a42820, 32'h10a7000a, 32'h0064202a, 32'h10800001, 32'h20050000,
        32'h00e2202a, 32'h00853820, 32'h00e23822, 32'hac670044, 32'h8c020050,
        32'h08000011, 32'h20020001, 32'hac020054, 32'h2067fff7, 32'h00000020,
        32'hac020050, 32'h08000015
    };

    always #5 clk = ~clk;

    imem_loadable #(.DEPTH(64)) u_d64 (
        .clk(clk), .reset(reset), .addr(addr), .instr(instr), .fetch_fault(fetch_fault),
        .stall(stall), .load_mode(load_mode), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .load_done(load_done), .load_count(load_count),
        .overflow(overflow)
    );

    imem_loadable #(.DEPTH(16)) u_d16 (
        .clk(clk), .reset(reset), .addr(addr), .instr(instr16), .fetch_fault(fault16),
        .stall(stall16), .load_mode(ld16), .wr_valid(wv16), .wr_data(wd16),
        .wr_ready(ready16), .load_done(done16), .load_count(count16),
        .overflow(ovf16)
    );

    imem_loadable #(.DEPTH(48)) u_d48 (
        .clk(clk), .reset(reset), .addr(addr), .instr(instr48), .fetch_fault(fault48),
        .stall(stall48), .load_mode(load_mode), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(ready48), .load_done(done48), .load_count(count48),
        .overflow(ovf48)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until the 64-word sweep ends; the bound turns a hang into a failure.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (stall === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd64);
    endtask

    task automatic drain64();
        sb_t e;
        while (sb64.size() > 0) begin
            e    = sb64.pop_front();
            addr = e.a;
            #1;
            check("fetch64", instr, e.d);
            check("fetch64_fault", 32'(fetch_fault), 32'd0);
        end
    endtask

    task automatic drain16();
        sb_t e;
        while (sb16.size() > 0) begin
            e    = sb16.pop_front();
            addr = e.a;
            #1;
            check("fetch16", instr16, e.d);
        end
    endtask

    // Streams stream_q into the 64-word instance; an idle cycle precedes every gap-th beat.
    task automatic run_load64(input int gap);
        int n;
        n         = stream_q.size();
        load_mode = 1'b1;
        tick();
        check("load_entry_stall", 32'(stall), 32'd1);
        check("load_entry_count", 32'(load_count), 32'd0);
        if (n == 0) begin
            load_mode = 1'b0;
            tick();
        end
        for (int i = 0; i < n; i++) begin
            if (gap != 0 && (i % gap) == gap - 1) begin
                wr_valid = 1'b0;
                tick();
            end
            wr_valid = 1'b1;
            wr_data  = stream_q[i];
            check("load_ready", 32'(wr_ready), 32'd1);
            sb64.push_back({8'(i * 4), stream_q[i]});
            if (i == n - 1) load_mode = 1'b0;
            tick();
        end
        wr_valid = 1'b0;
        check("load_done_pulse", 32'(load_done), 32'd1);
        check("load_count", 32'(load_count), 32'(n));
        check("run_after_load", 32'(stall), 32'd0);
        tick();
        check("load_done_clear", 32'(load_done), 32'd0);
        check("load_count_held", 32'(load_count), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        addr      = 8'h00;
        load_mode = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        ld16      = 1'b0;
        wv16      = 1'b0;
        wd16      = '0;
        repeat (3) tick();

        check("rst_stall", 32'(stall), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_instr_nop", instr, 32'h0);

        // Clear sweep, then every aligned word reads back as NOP.
        reset = 1'b1;
        wait_clear("clear_len");
        for (int i = 0; i < 64; i++) sb64.push_back({8'(i * 4), 32'h0});
        drain64();

        // Program load with wr_valid gaps.
        stream_q.delete();
        for (int i = 0; i < 22; i++) stream_q.push_back(prog[i]);
        run_load64(3);
        drain64();
        addr = 8'h58;
        #1;
        check("after_prog", instr, 32'h0);

        // Fetch faults and range boundaries.
        addr = 8'h06;
        #1;
        check("misaligned_instr", instr, 32'h0);
        check("misaligned_fault", 32'(fetch_fault), 32'd1);
        addr = 8'hC0;
        #1;
        check("d48_oob_fault", 32'(fault48), 32'd1);
        check("d48_oob_instr", instr48, 32'h0);
        check("d64_c0_fault", 32'(fetch_fault), 32'd0);
        addr = 8'hFC;
        #1;
        check("d64_top_fault", 32'(fetch_fault), 32'd0);
        check("d64_top_instr", instr, 32'h0);

        // Empty load: one LOAD cycle, count 0, done still pulses.
        stream_q.delete();
        run_load64(0);

        // Partial reload keeps untouched words.
        stream_q.delete();
        stream_q.push_back(32'h2402000a);
        stream_q.push_back(32'h2403000b);
        run_load64(0);
        drain64();
        addr = 8'h08;
        #1;
        check("reload_keep_w2", instr, 32'h04000000);
        addr = 8'h0C;
        #1;
        check("reload_keep_w3", instr, 32'h00e22025);

        // Overflow on the 16-word instance.
        ld16 = 1'b1;
        tick();
        for (int i = 0; i < 18; i++) begin
            wv16 = 1'b1;
            wd16 = 32'h10000000 + 32'(i);
            check("d16_ready", 32'(ready16), (i < 16) ? 32'd1 : 32'd0);
            if (i == 16) check("d16_ovf_before", 32'(ovf16), 32'd0);
            if (i == 17) check("d16_ovf_set", 32'(ovf16), 32'd1);
            if (i < 16) sb16.push_back({8'(i * 4), 32'h10000000 + 32'(i)});
            tick();
        end
        wv16 = 1'b0;
        ld16 = 1'b0;
        tick();
        check("d16_done", 32'(done16), 32'd1);
        check("d16_count", 32'(count16), 32'd16);
        check("d16_run", 32'(stall16), 32'd0);
        tick();
        check("d16_ovf_sticky", 32'(ovf16), 32'd1);
        drain16();
        addr = 8'h40;
        #1;
        check("d16_oob_fault", 32'(fault16), 32'd1);
        check("d16_oob_instr", instr16, 32'h0);

        // Reset in the middle of a load aborts it and restarts the sweep.
        load_mode = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hA0000000 + 32'(i);
            tick();
        end
        wr_valid = 1'b0;
        check("abort_pre_count", 32'(load_count), 32'd5);
        reset = 1'b0;
        tick();
        check("abort_stall", 32'(stall), 32'd1);
        check("abort_count", 32'(load_count), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        check("abort_ready", 32'(wr_ready), 32'd0);
        load_mode = 1'b0;
        reset     = 1'b1;
        wait_clear("reclear_len");
        sb64.push_back({8'h00, 32'h0});
        sb64.push_back({8'h08, 32'h0});
        drain64();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
